// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_pkg
//  Purpose  : Shared types and index helpers for the stream_mux_rr channel
//             selector (round-robin search, one-hot to index conversion).
//  Contents : arb_mode_e      - arbitration mode encoding of the mode input
//             MAX_CHANNELS    - widest request vector the helpers accept
//             rr_next()       - first set request at or above a pointer,
//                               wrapping at n
//             onehot_to_idx() - index of the set bit of a one-hot vector
//  Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam int MAX_CHANNELS = 64;

    typedef logic [MAX_CHANNELS-1:0] chan_vec_t;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Scan n request bits starting at ptr, wrapping to 0 after n-1. Returns
    // the first requester found, or 0 when nothing requests (callers qualify
    // the result with the OR of the request vector).
    function automatic int rr_next(input chan_vec_t req, input int ptr, input int n);
        int        res;
        int        idx;
        logic      found;
        chan_vec_t shifted;
        res   = 0;
        found = 1'b0;
        for (int k = 0; k < MAX_CHANNELS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                shifted = req >> idx;
                if (!found && shifted[0]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // OR-reduction encoder: valid for one-hot or all-zero inputs.
    function automatic int onehot_to_idx(input chan_vec_t oh);
        int res;
        res = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (oh[i]) begin
                res = res | i;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Grants the first requesting
//             channel at or above the pointer, wrapping at CHANNELS.
//  Ports    : i_req   [CHANNELS] request vector
//             i_ptr   [SELW]     highest-priority channel this cycle
//             o_grant [CHANNELS] one-hot grant, zero when nothing requests
//             o_idx   [SELW]     index of the granted channel (0 if none)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SELW-1:0]     i_ptr,
    output logic [CHANNELS-1:0] o_grant,
    output logic [SELW-1:0]     o_idx
);

    int w_pick;

    always_comb begin
        w_pick  = rr_next(chan_vec_t'(i_req), int'(i_ptr), CHANNELS);
        o_grant = '0;
        if (|i_req) begin
            o_grant = CHANNELS'(1) << w_pick;
        end
        o_idx = SELW'(onehot_to_idx(chan_vec_t'(o_grant)));
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Purpose  : Registered N-way stream multiplexer with valid/ready handshake.
//             Round-robin (mode=0) or fixed select (mode=1) arbitration, one
//             output register stage, one beat per clock without backpressure.
//  Ports    : clk, reset (async, active high)
//             mode, sel            arbitration control
//             in_data/in_valid/in_last/in_ready   CHANNELS input streams,
//                                  channel i at in_data[i*WIDTH +: WIDTH]
//             out_data/out_chan/out_last/out_valid/out_ready  output stream
//  Config   : STREAM_MUX_PKT_LOCK_EN - when defined, a beat with in_last=0
//             locks the grant to its channel until that channel's in_last=1
//             beat is transferred.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_chan;
    logic                r_out_last;
    logic                r_out_valid;
    logic [SELW-1:0]     r_rr_ptr;

    logic                w_load_en;
    logic [CHANNELS-1:0] w_rr_grant;
    logic [SELW-1:0]     w_rr_idx;
    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_gidx;
    logic [CHANNELS-1:0] w_xfer_vec;
    logic                w_xfer;
    logic                w_xfer_last;
    logic [WIDTH-1:0]    w_sel_data;
    logic [SELW-1:0]     w_next_ptr;
    logic                w_ptr_adv;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic                r_lock;
    logic [SELW-1:0]     r_lock_chan;
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx)
    );

    // The output register can take a new beat when empty or being drained.
    assign w_load_en = !r_out_valid || out_ready;

    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        if (mode == ARB_FIXED) begin
            // Out-of-range select (non power-of-two CHANNELS) grants nobody.
            if (int'(sel) < CHANNELS) begin
                w_grant = CHANNELS'(1) << sel;
                w_gidx  = sel;
            end
        end else begin
            w_grant = w_rr_grant;
            w_gidx  = w_rr_idx;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        // An open packet owns the output regardless of mode, sel or others.
        if (r_lock) begin
            w_grant = CHANNELS'(1) << r_lock_chan;
            w_gidx  = r_lock_chan;
        end
`endif
    end

    // Gated by reset so no producer sees a handshake while the block is held.
    assign in_ready    = (w_load_en && !reset) ? w_grant : '0;
    assign w_xfer_vec  = in_valid & in_ready;
    assign w_xfer      = |w_xfer_vec;
    assign w_xfer_last = |(w_xfer_vec & in_last);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_next_ptr = (int'(w_gidx) == CHANNELS - 1) ? '0 : w_gidx + 1'b1;

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Pointer moves past a channel only once its packet is complete.
    assign w_ptr_adv = w_xfer && w_xfer_last;
`else
    assign w_ptr_adv = w_xfer;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_gidx;
                r_out_last  <= w_xfer_last;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_ptr_adv) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
        end else if (w_xfer) begin
            if (!w_xfer_last) begin
                r_lock      <= 1'b1;
                r_lock_chan <= w_gidx;
            end else begin
                r_lock      <= 1'b0;
            end
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_rr
//  Purpose  : Self-checking bench for stream_mux_rr: directed vector table,
//             hand-written corner sequences and randomized traffic compared
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    localparam int WIDTH = 16;
    localparam int CH    = 4;
    localparam int SELW  = 2;

    logic                clk;
    logic                reset;
    logic                mode;
    logic [SELW-1:0]     sel;
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_last;
    logic [CH-1:0]       in_ready;
    logic [WIDTH-1:0]    out_data;
    logic [SELW-1:0]     out_chan;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;

    stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_chan;
    bit               m_last;
    int               m_ptr;
    bit               m_lock;
    int               m_lock_chan;

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_chan = 0; m_last = 0;
        m_ptr = 0; m_lock = 0; m_lock_chan = 0;
    endtask

    function automatic bit bit_of(input logic [CH-1:0] v, input int c);
        logic [CH-1:0] t;
        t = v >> c;
        return t[0];
    endfunction

    function automatic int model_grant();
        int c;
        if (m_lock) return m_lock_chan;
        if (mode) return (int'(sel) < CH) ? int'(sel) : -1;
        for (int k = 0; k < CH; k++) begin
            c = (m_ptr + k) % CH;
            if (bit_of(in_valid, c)) return c;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] model_ready();
        int g;
        g = model_grant();
        if (reset || !(!m_valid || out_ready) || g < 0) return '0;
        return CH'(1) << g;
    endfunction

    // One clock: check in_ready before the edge, advance the model, then
    // check the output register after the edge.
    task automatic cycle(input string tag);
        logic [CH-1:0] er;
        int            g;
        bit            xfer;
        #1;
        er   = model_ready();
        g    = model_grant();
        chk({tag, " in_ready"}, 32'(in_ready), 32'(er));
        xfer = (er != 0) && bit_of(in_valid, g);
        @(posedge clk);
        if (xfer) begin
            m_valid = 1;
            m_data  = WIDTH'(in_data >> (g * WIDTH));
            m_chan  = g;
            m_last  = bit_of(in_last, g);
`ifdef STREAM_MUX_PKT_LOCK_EN
            if (!m_last) begin
                m_lock = 1; m_lock_chan = g;
            end else begin
                m_lock = 0; m_ptr = (g + 1) % CH;
            end
`else
            m_ptr = (g + 1) % CH;
`endif
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, " out_data"},  32'(out_data),  32'(m_data));
        chk({tag, " out_chan"},  32'(out_chan),  32'(m_chan));
        chk({tag, " out_last"},  32'(out_last),  32'(m_last));
    endtask

    task automatic fixed_data();
        for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = 16'h00A0 + 16'(i);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         mode;
        logic [1:0] sel;
        logic [3:0] vld;
        bit         ordy;
        logic [3:0] exp_rdy;
        bit         exp_valid;
        int         exp_chan;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // round robin, all valid
        tbl[0]  = '{0, 0, 4'b1111, 1, 4'b0001, 1, 0};
        tbl[1]  = '{0, 0, 4'b1111, 1, 4'b0010, 1, 1};
        tbl[2]  = '{0, 0, 4'b1111, 1, 4'b0100, 1, 2};
        tbl[3]  = '{0, 0, 4'b1111, 1, 4'b1000, 1, 3};
        tbl[4]  = '{0, 0, 4'b1111, 1, 4'b0001, 1, 0};
        // sparse wrap from pointer 1
        tbl[5]  = '{0, 0, 4'b1001, 1, 4'b1000, 1, 3};
        tbl[6]  = '{0, 0, 4'b1001, 1, 4'b0001, 1, 0};
        tbl[7]  = '{0, 0, 4'b1001, 1, 4'b1000, 1, 3};
        // fixed select channel 2
        tbl[8]  = '{1, 2, 4'b1111, 1, 4'b0100, 1, 2};
        tbl[9]  = '{1, 2, 4'b1111, 1, 4'b0100, 1, 2};
        tbl[10] = '{1, 2, 4'b1111, 1, 4'b0100, 1, 2};
        // one beat, three stalled cycles, then drain+load on the same edge
        tbl[11] = '{0, 0, 4'b1111, 1, 4'b1000, 1, 3};
        tbl[12] = '{0, 0, 4'b1111, 0, 4'b0000, 1, 3};
        tbl[13] = '{0, 0, 4'b1111, 0, 4'b0000, 1, 3};
        tbl[14] = '{0, 0, 4'b1111, 0, 4'b0000, 1, 3};
        tbl[15] = '{0, 0, 4'b1111, 1, 4'b0001, 1, 0};
        // drain with nothing to load: valid drops, channel holds
        tbl[16] = '{0, 0, 4'b0000, 1, 4'b0000, 0, 0};

        // ---------------- reset with all inputs valid ----------------
        reset = 1'b1; mode = 1'b0; sel = '0; in_valid = 4'b1111;
        in_last = '0; out_ready = 1'b1;
        fixed_data();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(in_ready),  32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data",  32'(out_data),  32'h0);
        chk("reset out_chan",  32'(out_chan),  32'h0);
        chk("reset out_last",  32'(out_last),  32'h0);
        reset = 1'b0;

        // ---------------- table ----------------
        for (int v = 0; v < 17; v++) begin
            mode = tbl[v].mode; sel = tbl[v].sel;
            in_valid = tbl[v].vld; out_ready = tbl[v].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'(tbl[v].exp_rdy));
            cycle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl out_valid", v), 32'(out_valid), 32'(tbl[v].exp_valid));
            chk($sformatf("vec%0d tbl out_chan", v),  32'(out_chan),  32'(tbl[v].exp_chan));
        end

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            mode      = ($urandom_range(3) == 0);
            sel       = SELW'($urandom_range(CH - 1));
            in_valid  = CH'($urandom);
            in_last   = CH'($urandom);
            out_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            cycle("rand");
        end

        // ---------------- reset while a beat is held ----------------
        mode = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b0;
        fixed_data();
        cycle("pre-reset");
        #2;
        reset = 1'b1;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'h0);
        chk("midreset out_data",  32'(out_data),  32'h0);
        chk("midreset out_chan",  32'(out_chan),  32'h0);
        chk("midreset in_ready",  32'(in_ready),  32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        cycle("post-reset");
        chk("post-reset chan0", 32'(out_chan), 32'h0);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // ---------------- packet lock ----------------
        in_valid = 4'b0001; in_last = 4'b0001;
        cycle("lock setup");
        in_valid = 4'b0011;
        in_last  = 4'b0001;
        cycle("lock b0");
        chk("lock b0 chan", 32'(out_chan), 32'h1);
        cycle("lock b1");
        chk("lock b1 chan", 32'(out_chan), 32'h1);
        in_last  = 4'b0011;
        cycle("lock b2");
        chk("lock b2 chan", 32'(out_chan), 32'h1);
        cycle("lock after");
        chk("lock after chan", 32'(out_chan), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
